// File: rtl/mem_rw_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_rw_master
// Purpose  : Burst command master that turns INCR/WRAP read and write
//            commands into single-beat accesses on a simple memory port.
//            Reads sustain one beat per cycle when the consumer is ready.
// Revision : 1.0  initial release
// ============================================================================
module mem_rw_master #(
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    // command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [63:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_wrap,
    // write-beat channel
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [63:0]      wdata,
    input  logic [7:0]       wstrb,
    // read-beat channel
    output logic             rdata_valid,
    input  logic             rdata_ready,
    output logic [63:0]      rdata,
    output logic             rdata_last,
    // write completion
    output logic             wresp_valid,
    input  logic             wresp_ready,
    // memory read port
    output logic             r_enable,
    output logic [63:0]      r_index,
    input  logic [63:0]      r_data,
    // memory write port
    output logic             w_enable,
    output logic [63:0]      w_index,
    output logic [63:0]      w_data,
    output logic [63:0]      w_mask
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ISSUE = 3'd1;
    localparam logic [2:0] S_RD_RESP  = 3'd2;
    localparam logic [2:0] S_WR_DATA  = 3'd3;
    localparam logic [2:0] S_WR_RESP  = 3'd4;

    logic [2:0]       r_state;
    logic [60:0]      r_beat_idx;   // current 8-byte word index
    logic [LEN_W-1:0] r_len;        // beats minus one of the active burst
    logic [LEN_W-1:0] r_cnt;        // beats completed so far
    logic             r_wrap;

    logic             w_last;
    logic             w_len_hi_zero;
    logic [3:0]       w_len_lo;
    logic             w_wrap_ok;
    logic [60:0]      w_wrap_mask;
    logic [60:0]      w_idx_inc;
    logic [60:0]      w_idx_next;
    logic             w_rd_hs;
    logic             w_wr_hs;
    logic [63:0]      w_byte_mask;
    logic             w_unused;

    // The three byte-offset bits of the address never reach the word index.
    assign w_unused = ^cmd_addr[2:0];

    assign w_last   = (r_cnt == r_len);
    assign w_len_lo = 4'(r_len);

    // Only lengths that fit in four bits can select a wrapping window.
    generate
        if (LEN_W > 4) begin : g_len_wide
            assign w_len_hi_zero = (r_len[LEN_W-1:4] == '0);
        end else begin : g_len_narrow
            assign w_len_hi_zero = 1'b1;
        end
    endgenerate

    // Decide whether the burst wraps: WRAP with 2, 4, 8 or 16 beats.
    always_comb begin
        w_wrap_ok = 1'b0;
        if (r_wrap && w_len_hi_zero) begin
            case (w_len_lo)
                4'd1, 4'd3, 4'd7, 4'd15: w_wrap_ok = 1'b1;
                default:                 w_wrap_ok = 1'b0;
            endcase
        end
    end

    // An all-ones mask turns the merge below into a plain 61-bit increment,
    // so INCR and non-wrapping WRAP share one datapath.
    assign w_wrap_mask = w_wrap_ok ? {57'd0, w_len_lo} : {61{1'b1}};
    assign w_idx_inc   = r_beat_idx + 61'd1;
    assign w_idx_next  = (r_beat_idx & ~w_wrap_mask) | (w_idx_inc & w_wrap_mask);

    // Beat handshakes; reset suppresses them so an abandoned burst never
    // touches memory at the reset edge.
    assign w_rd_hs = reset_n && (r_state == S_RD_RESP) && rdata_ready;
    assign w_wr_hs = reset_n && (r_state == S_WR_DATA) && wdata_valid;

    // Expand per-byte strobes into a per-bit write mask.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mask
            assign w_byte_mask[8*gi +: 8] = {8{wstrb[gi]}};
        end
    endgenerate

    // Burst sequencing: command capture, beat counting, index advance.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_beat_idx <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_wrap     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_beat_idx <= cmd_addr[63:3];
                        r_len      <= cmd_len;
                        r_wrap     <= cmd_wrap;
                        r_cnt      <= '0;
                        r_state    <= cmd_write ? S_WR_DATA : S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE: begin
                    r_state <= S_RD_RESP;
                end
                S_RD_RESP: begin
                    if (rdata_ready) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_beat_idx <= w_idx_next;
                            r_cnt      <= r_cnt + LEN_W'(1);
                        end
                    end
                end
                S_WR_DATA: begin
                    if (wdata_valid) begin
                        r_beat_idx <= w_idx_next;
                        if (w_last) begin
                            r_state <= S_WR_RESP;
                        end else begin
                            r_cnt <= r_cnt + LEN_W'(1);
                        end
                    end
                end
                S_WR_RESP: begin
                    if (wresp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake, memory-port and data outputs decoded from the state.
    always_comb begin
        cmd_ready   = reset_n && (r_state == S_IDLE);
        wdata_ready = reset_n && (r_state == S_WR_DATA);
        rdata_valid = reset_n && (r_state == S_RD_RESP);
        wresp_valid = reset_n && (r_state == S_WR_RESP);
        rdata       = r_data;
        rdata_last  = (r_state == S_RD_RESP) && w_last;

        // First beat issues from the latched index; later beats issue the
        // advanced index in the same cycle the previous beat is consumed.
        r_enable = reset_n && ((r_state == S_RD_ISSUE) || (w_rd_hs && !w_last));
        r_index  = '0;
        if (r_enable) begin
            r_index = (r_state == S_RD_RESP) ? {3'b000, w_idx_next}
                                             : {3'b000, r_beat_idx};
        end

        w_enable = w_wr_hs;
        w_index  = w_enable ? {3'b000, r_beat_idx} : 64'd0;
        w_data   = w_enable ? wdata                 : 64'd0;
        w_mask   = w_enable ? w_byte_mask           : 64'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_rw_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_rw_master
// Purpose  : Self-checking bench for mem_rw_master: table of bursts with
//            explicit expected word indices, a registered memory model and
//            queues of expected memory accesses and read beats.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_rw_master;

    localparam int LEN_W = 8;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [63:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_wrap;
    logic             wdata_valid;
    logic             wdata_ready;
    logic [63:0]      wdata;
    logic [7:0]       wstrb;
    logic             rdata_valid;
    logic             rdata_ready;
    logic [63:0]      rdata;
    logic             rdata_last;
    logic             wresp_valid;
    logic             wresp_ready;
    logic             r_enable;
    logic [63:0]      r_index;
    logic [63:0]      r_data;
    logic             w_enable;
    logic [63:0]      w_index;
    logic [63:0]      w_data;
    logic [63:0]      w_mask;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_rw_master #(.LEN_W(LEN_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_wrap    (cmd_wrap),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .wresp_valid (wresp_valid),
        .wresp_ready (wresp_ready),
        .r_enable    (r_enable),
        .r_index     (r_index),
        .r_data      (r_data),
        .w_enable    (w_enable),
        .w_index     (w_index),
        .w_data      (w_data),
        .w_mask      (w_mask)
    );

    // Memory content is a fixed function of the word index.
    function automatic logic [63:0] mem_word(input logic [63:0] idx);
        return {~idx[31:0], idx[31:0]} ^ 64'h5A5A_0F0F_A5A5_F0F0;
    endfunction

    // Registered read port: data one clock after r_enable, held otherwise.
    logic [63:0] mem_q = 64'd0;
    always @(posedge clock) if (r_enable) mem_q <= mem_word(r_index);
    assign r_data = mem_q;

    // Scoreboard queues.
    logic [60:0]  q_ridx[$];
    logic [64:0]  q_rdat[$];   // {last, data}
    logic [191:0] q_wr[$];     // {index, data, mask}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every memory access and every accepted read beat is matched
    // against the head of its expectation queue.
    always @(negedge clock) begin
        if (r_enable || w_enable)
            check("r/w enable exclusive", 64'(r_enable & w_enable), 64'd0);
        if (r_enable) begin
            if (q_ridx.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected r_enable: r_index=%h required no access", r_index);
            end else begin
                check("r_index", r_index, {3'b000, q_ridx.pop_front()});
            end
        end
        if (w_enable) begin
            if (q_wr.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected w_enable: w_index=%h required no access", w_index);
            end else begin
                logic [191:0] e;
                e = q_wr.pop_front();
                check("w_index", w_index, e[191:128]);
                check("w_data", w_data, e[127:64]);
                check("w_mask", w_mask, e[63:0]);
            end
        end
        if (rdata_valid && rdata_ready) begin
            if (q_rdat.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected read beat: rdata=%h required none", rdata);
            end else begin
                logic [64:0] e;
                e = q_rdat.pop_front();
                check("rdata", rdata, e[63:0]);
                check("rdata_last", 64'(rdata_last), 64'(e[64]));
            end
        end
    end

    typedef struct {
        bit               wr;
        logic [63:0]      addr;
        int               len;
        bit               wrap;
        int               stall_beat;
        int               stall_n;
        logic [63:0]      strb;   // byte strobes of beat b in [8*b +: 8]
        logic [7:0][60:0] eidx;   // expected word index of each beat
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit wr, input logic [63:0] addr, input int len, input bit wrap,
                       input int sb, input int sn, input logic [63:0] strb,
                       input logic [60:0] e0, input logic [60:0] e1, input logic [60:0] e2,
                       input logic [60:0] e3, input logic [60:0] e4, input logic [60:0] e5,
                       input logic [60:0] e6, input logic [60:0] e7);
        vec_t v;
        v.wr = wr; v.addr = addr; v.len = len; v.wrap = wrap;
        v.stall_beat = sb; v.stall_n = sn; v.strb = strb;
        v.eidx[0] = e0; v.eidx[1] = e1; v.eidx[2] = e2; v.eidx[3] = e3;
        v.eidx[4] = e4; v.eidx[5] = e5; v.eidx[6] = e6; v.eidx[7] = e7;
        tbl.push_back(v);
    endtask

    task automatic send_cmd(input bit wr, input logic [63:0] addr, input int len, input bit wrap);
        cmd_write = wr; cmd_addr = addr; cmd_len = LEN_W'(len); cmd_wrap = wrap;
        cmd_valid = 1'b1;
        @(negedge clock);
        check("cmd_ready in idle", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_read(input vec_t v);
        int beat, cyc, stall_left;
        for (int b = 0; b <= v.len; b++) begin
            q_ridx.push_back(v.eidx[b]);
            q_rdat.push_back({1'(b == v.len), mem_word({3'b000, v.eidx[b]})});
        end
        send_cmd(1'b0, v.addr, v.len, v.wrap);
        beat = 0; cyc = 0; stall_left = v.stall_n;
        while (beat <= v.len && cyc < 64) begin
            rdata_ready = !(beat == v.stall_beat && stall_left > 0);
            @(negedge clock);
            if (rdata_valid) begin
                if (!rdata_ready) begin
                    check("stall r_enable", 64'(r_enable), 64'd0);
                    check("stall rdata", rdata, mem_word({3'b000, v.eidx[beat]}));
                    check("stall rdata_last", 64'(rdata_last), 64'(beat == v.len));
                    stall_left--;
                end else begin
                    if (beat == v.len)
                        check("read last-beat cycle", 64'(cyc), 64'(v.len + 1 + v.stall_n));
                    beat++;
                end
            end
            tick();
            cyc++;
        end
        rdata_ready = 1'b1;
        if (beat <= v.len) begin
            total++; bad++;
            $display("FAIL read timeout: beats=%0d required %0d", beat, v.len + 1);
        end
        @(negedge clock);
        check("idle after read", 64'(cmd_ready), 64'd1);
    endtask

    task automatic run_write(input vec_t v);
        logic [63:0] wds[8];
        logic [63:0] m;
        int beat, cyc, stall_left;
        for (int b = 0; b <= v.len; b++) begin
            wds[b] = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) m[8*i +: 8] = v.strb[8*b + i] ? 8'hFF : 8'h00;
            q_wr.push_back({{3'b000, v.eidx[b]}, wds[b], m});
        end
        send_cmd(1'b1, v.addr, v.len, v.wrap);
        beat = 0; cyc = 0; stall_left = v.stall_n;
        while (beat <= v.len && cyc < 64) begin
            wdata_valid = !(beat == v.stall_beat && stall_left > 0);
            wdata = wds[beat];
            wstrb = v.strb[8*beat +: 8];
            @(negedge clock);
            if (!wdata_valid) begin
                check("write bubble w_enable", 64'(w_enable), 64'd0);
                stall_left--;
            end else if (wdata_ready) begin
                if (beat == v.len)
                    check("write last-beat cycle", 64'(cyc), 64'(v.len + v.stall_n));
                beat++;
            end
            tick();
            cyc++;
        end
        if (beat <= v.len) begin
            total++; bad++;
            $display("FAIL write timeout: beats=%0d required %0d", beat, v.len + 1);
        end
        // Surplus beat stays offered; it must not be accepted.
        wdata_valid = 1'b1;
        wresp_ready = 1'b0;
        @(negedge clock);
        check("wresp_valid after last beat", 64'(wresp_valid), 64'd1);
        check("no surplus wdata_ready", 64'(wdata_ready), 64'd0);
        tick();
        wresp_ready = 1'b1;
        @(negedge clock);
        check("wresp_valid held", 64'(wresp_valid), 64'd1);
        tick();
        wresp_ready = 1'b0;
        wdata_valid = 1'b0;
        @(negedge clock);
        check("idle after write", 64'(cmd_ready), 64'd1);
        check("wresp_valid cleared", 64'(wresp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded, required finish before 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 64'd0;
        cmd_len = '0; cmd_wrap = 1'b0; wdata_valid = 1'b1; wdata = 64'hDEAD_BEEF_CAFE_F00D;
        wstrb = 8'hFF; rdata_ready = 1'b1; wresp_ready = 1'b0;

        // Reset state, including gated write data while wdata is nonzero.
        tick(); tick();
        reset_n = 1'b1;
        @(negedge clock);
        check("reset cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset r_enable", 64'(r_enable), 64'd0);
        check("reset w_enable", 64'(w_enable), 64'd0);
        check("reset rdata_valid", 64'(rdata_valid), 64'd0);
        check("reset wresp_valid", 64'(wresp_valid), 64'd0);
        check("reset wdata_ready", 64'(wdata_ready), 64'd0);
        check("reset r_index", r_index, 64'd0);
        check("reset w_index", w_index, 64'd0);
        check("reset w_data", w_data, 64'd0);
        check("reset w_mask", w_mask, 64'd0);
        tick();
        wdata_valid = 1'b0;

        //   wr addr                     len wrap sb  sn strb
        add(0, 64'h1000,               3, 0, -1, 0, 64'h0, 61'h200, 61'h201, 61'h202, 61'h203, 0, 0, 0, 0);
        add(0, 64'h1000,               3, 0,  1, 3, 64'h0, 61'h200, 61'h201, 61'h202, 61'h203, 0, 0, 0, 0);
        add(1, 64'h2008,               1, 0, -1, 0, 64'hF00F, 61'h401, 61'h402, 0, 0, 0, 0, 0, 0);
        add(0, 64'h1010,               3, 1, -1, 0, 64'h0, 61'h202, 61'h203, 61'h200, 61'h201, 0, 0, 0, 0);
        add(0, 64'h1010,               2, 1, -1, 0, 64'h0, 61'h202, 61'h203, 61'h204, 0, 0, 0, 0, 0);
        add(0, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0, -1, 0, 64'h0, 61'h1FFF_FFFF_FFFF_FFFF, 61'h0, 0, 0, 0, 0, 0, 0);
        add(0, 64'h3F,                 0, 0, -1, 0, 64'h0, 61'h7, 0, 0, 0, 0, 0, 0, 0);
        add(1, 64'h1018,               1, 1, -1, 0, 64'h3CA5, 61'h203, 61'h202, 0, 0, 0, 0, 0, 0);
        add(1, 64'h10,                 3, 1,  2, 2, 64'h7E81_00FF, 61'h2, 61'h3, 61'h0, 61'h1, 0, 0, 0, 0);
        add(0, 64'h828,                7, 1,  5, 1, 64'h0, 61'h105, 61'h106, 61'h107, 61'h100,
            61'h101, 61'h102, 61'h103, 61'h104);
        add(1, 64'h38,                 2, 1, -1, 0, 64'h04_0201, 61'h7, 61'h8, 61'h9, 0, 0, 0, 0, 0);
        add(0, 64'h7FF8,               1, 1,  0, 2, 64'h0, 61'hFFF, 61'hFFE, 0, 0, 0, 0, 0, 0);

        for (int t = 0; t < tbl.size(); t++) begin
            if (tbl[t].wr) run_write(tbl[t]);
            else           run_read(tbl[t]);
            tick();
        end

        // Write burst abandoned by reset after two beats.
        q_wr.push_back({64'h600, 64'h1111_2222_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF});
        q_wr.push_back({64'h601, 64'h5555_6666_7777_8888, 64'hFFFF_FFFF_FFFF_FFFF});
        send_cmd(1'b1, 64'h3000, 3, 1'b0);
        wstrb = 8'hFF;
        wdata_valid = 1'b1; wdata = 64'h1111_2222_3333_4444;
        @(negedge clock); tick();
        wdata = 64'h5555_6666_7777_8888;
        @(negedge clock); tick();
        reset_n = 1'b0;
        wdata = 64'h9999_AAAA_BBBB_CCCC;
        @(negedge clock);
        check("reset mid-write w_enable", 64'(w_enable), 64'd0);
        check("reset mid-write wresp_valid", 64'(wresp_valid), 64'd0);
        tick(); tick();
        reset_n = 1'b1;
        @(negedge clock);
        check("cmd_ready after write reset", 64'(cmd_ready), 64'd1);
        for (int c = 0; c < 4; c++) begin
            check("wresp_valid after abandon", 64'(wresp_valid), 64'd0);
            tick();
            @(negedge clock);
        end
        wdata_valid = 1'b0;
        tick();

        // Read burst abandoned by reset on beat 1.
        q_ridx.push_back(61'h200);
        q_ridx.push_back(61'h201);
        q_rdat.push_back({1'b0, mem_word(64'h200)});
        send_cmd(1'b0, 64'h1000, 3, 1'b0);
        @(negedge clock); tick();          // issue cycle
        @(negedge clock); tick();          // beat 0 accepted, beat 1 issued
        reset_n = 1'b0;
        @(negedge clock);
        check("reset mid-read rdata_valid", 64'(rdata_valid), 64'd0);
        check("reset mid-read r_enable", 64'(r_enable), 64'd0);
        check("reset mid-read rdata follows memory", rdata, mem_word(64'h201));
        tick();
        reset_n = 1'b1;
        @(negedge clock);
        check("cmd_ready after read reset", 64'(cmd_ready), 64'd1);
        tick(); tick();

        check("r_index queue drained", 64'(q_ridx.size()), 64'd0);
        check("read beat queue drained", 64'(q_rdat.size()), 64'd0);
        check("write queue drained", 64'(q_wr.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
